dcache_bus_router: RTL and testbench
====================================

# dcache_bus_router

Bridges the data-cache controller's internal bus request port to the shared memory interface (ADDR/BURST/REQ/WRB/ACK/STALL). Cacheable line fills and write-backs become 8-beat INCR bursts of 32-bit words. Peripheral or uncached accesses become single-word transfers. It sits between the D-cache controller and the memory arbiter, alongside the TLB walker that shares the memory port.

## Interface
- PERIPH_BASE, 8'h80, value of addr[31:24] that marks peripheral space
- LINE_WORDS, 8, 32-bit words per cache line (256 bits)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- biu_adr_i  in  32  request address
- biu_cyc_i / biu_stb_i  in  1  request valid; both must be high to start
- biu_we_i  in  1  1 = write, 0 = read
- biu_cab_i  in  1  1 = cacheable line access; 0 = single word
- biu_sel_i  in  4  byte enables for single-word access
- bus_wdata_i  in  256  line to write back, word k = bits [32k+31:32k]
- bus_rdata_o  out  256  assembled fill line
- biu_dat_o  out  32  single-word read data
- bus_rdy  out  1  transaction complete
- peripheral_access  out  1  current or last transaction is single-word
- freeze  in  1  blocks the start of a new transaction
- ADDR  out  32; BURST  out  2 (00 normal, 01 INCR, 10 WRAP); REQ  out  1; WRB  out  1 (1 = write)
- WDATA  out  32; BSTROBE  out  4; RDATA  in  32; ACK  in  1; STALL  in  1

## Operation
- States are IDLE, XFER and DONE.
- IDLE → XFER when biu_cyc_i & biu_stb_i & ~freeze. On entry, latch the request:
  - single = ~biu_cab_i | (biu_adr_i[31:24] == PERIPH_BASE)
  - peripheral_access = single
  - beat counter k = 0
- Line access:
  - base = {biu_adr_i[31:5], 5'b0}
  - BURST = 01, BSTROBE = 4'hF
  - ADDR = base + 4·k
  - writes: WDATA = bus_wdata_i word k
  - reads: RDATA is captured into bus_rdata_o word k
- Single access:
  - ADDR = biu_adr_i, BURST = 00, BSTROBE = biu_sel_i
  - writes: WDATA = bus_wdata_i word biu_adr_i[4:2]
  - reads: RDATA goes to biu_dat_o and to bus_rdata_o word biu_adr_i[4:2]
- WRB = latched biu_we_i. REQ = 1 throughout XFER.
- A beat completes on an edge where ACK = 1 and STALL = 0. ACK while STALL = 1 is ignored.
- XFER → DONE after beat LINE_WORDS-1 for a line access, or after beat 0 for a single access.
- DONE:
  - REQ = 0, bus_rdy = 1
  - stays in DONE while biu_cyc_i = 1 (four-phase handshake)
  - → IDLE when biu_cyc_i is sampled low
- freeze affects only the IDLE → XFER decision. It never aborts XFER or extends DONE.
- biu_dat_o, bus_rdata_o and peripheral_access hold their values until the next transaction overwrites them.
- There is no error or retry path.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE, REQ 0, WRB 0, ADDR 0, BURST 00, BSTROBE 0, WDATA 0
  - bus_rdy 0, peripheral_access 0, biu_dat_o 0, bus_rdata_o 0
- Reset asserted mid-transaction: the next edge returns to IDLE with REQ = 0. A partial fill line is discarded.
- Request accepted at edge 0 → REQ = 1 from cycle 1.
- With ACK every cycle, a line transfer completes beats on edges 1–8. DONE is entered and bus_rdy = 1 from cycle 9.
- With ACK every cycle, a single access completes its beat at edge 1 and bus_rdy = 1 from cycle 2.
- Each STALL cycle, or each cycle without ACK, adds one cycle.
- ADDR and WDATA update on the same edge as a completed beat, so the next beat's values appear in the following cycle.
- Minimum request-to-request spacing: DONE for at least 1 cycle, then IDLE for 1 cycle.

## Structure
- Shared package holds:
  - PERIPH_BASE default
  - BURST encodings (NORMAL, INCR, WRAP)
  - LINE_WORDS
  - state enum
- One module with a flat FSM, a 3-bit beat counter and a 256-bit line register. No sub-module is needed.

## Test plan
- Line read at 0x0000_1234, ACK every cycle, RDATA = 0x100+k:
  - REQ high for 8 cycles, BURST = 01, ADDR 0x1220…0x123C
  - bus_rdata_o word k = 0x100+k
  - bus_rdy at cycle 9, held until biu_cyc_i drops
- Line write with bus_wdata_i word k = 0xA0+k, STALL high on beat 3 for 2 cycles:
  - WRB = 1, WDATA sequence 0xA0…0xA7, each word presented exactly once per accepted beat
  - bus_rdy at cycle 11
- Peripheral read at 0x8000_0010, sel 4'b0011, RDATA 0xDEAD_BEEF:
  - BURST = 00, BSTROBE 0011, single beat
  - biu_dat_o = 0xDEADBEEF, peripheral_access = 1
- Request with freeze = 1 for 3 cycles:
  - REQ stays 0 until the cycle after freeze falls
  - freeze asserted mid-burst does not interrupt it
- reset low during beat 4 of a line read:
  - REQ = 0 and bus_rdy = 0 next cycle
  - a new request afterwards restarts at beat 0
- cab = 0, non-peripheral address 0x0000_2008, write, sel 1100:
  - single beat, BSTROBE 1100, WDATA = bus_wdata_i word 2

Source files
------------

// File: rtl/dcache_bus_router_pkg.sv
// Shared types and constants for the D-cache to memory-port bus router.
package dcache_bus_router_pkg;

  localparam logic [7:0] PERIPH_BASE = 8'h80;
  localparam int         LINE_WORDS  = 8;
  localparam int         LINE_BITS   = LINE_WORDS * 32;

  typedef enum logic [1:0] {
    BURST_NORMAL = 2'b00,
    BURST_INCR   = 2'b01,
    BURST_WRAP   = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_DONE = 2'b10
  } rtr_state_e;

  // Extract 32-bit word idx from a cache line.
  function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                            input logic [2:0]           idx);
    return line[{idx, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/dcache_bus_router.sv
// Converts D-cache line fills/write-backs into 8-beat INCR bursts and
// uncached/peripheral accesses into single-word transfers on the memory port.
module dcache_bus_router
  import dcache_bus_router_pkg::*;
#(
  parameter logic [7:0] PERIPH_BASE_P = PERIPH_BASE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          biu_adr_i,
  input  logic                 biu_cyc_i,
  input  logic                 biu_stb_i,
  input  logic                 biu_we_i,
  input  logic                 biu_cab_i,
  input  logic [3:0]           biu_sel_i,
  input  logic [LINE_BITS-1:0] bus_wdata_i,
  output logic [LINE_BITS-1:0] bus_rdata_o,
  output logic [31:0]          biu_dat_o,
  output logic                 bus_rdy,
  output logic                 peripheral_access,
  input  logic                 freeze,
  output logic [31:0]          ADDR,
  output logic [1:0]           BURST,
  output logic                 REQ,
  output logic                 WRB,
  output logic [31:0]          WDATA,
  output logic [3:0]           BSTROBE,
  input  logic [31:0]          RDATA,
  input  logic                 ACK,
  input  logic                 STALL
);

  rtr_state_e           state_r, state_nxt_s;
  logic                 single_r, single_nxt_s;
  logic [31:0]          adr_r, adr_nxt_s;
  logic [2:0]           beat_r, beat_nxt_s;
  logic [LINE_BITS-1:0] line_r, line_nxt_s;
  logic [31:0]          dat_r, dat_nxt_s;
  logic                 periph_r, periph_nxt_s;
  logic                 rdy_r, rdy_nxt_s;
  logic [31:0]          addr_r, addr_nxt_s;
  burst_e               burst_r, burst_nxt_s;
  logic                 req_r, req_nxt_s;
  logic                 wrb_r, wrb_nxt_s;
  logic [31:0]          wdata_r, wdata_nxt_s;
  logic [3:0]           strobe_r, strobe_nxt_s;

  logic                 start_s;
  logic                 req_single_s;
  logic                 beat_ok_s;
  logic                 last_beat_s;
  logic [2:0]           beat_inc_s;
  logic [2:0]           rd_idx_s;

  assign start_s      = biu_cyc_i & biu_stb_i & ~freeze;
  assign req_single_s = ~biu_cab_i | (biu_adr_i[31:24] == PERIPH_BASE_P);
  assign beat_ok_s    = ACK & ~STALL;
  assign last_beat_s  = single_r | (beat_r == 3'(LINE_WORDS - 1));
  assign beat_inc_s   = beat_r + 3'd1;
  // Single reads land in the line slot selected by the word offset.
  assign rd_idx_s     = single_r ? adr_r[4:2] : beat_r;

  // Next-state logic for the transaction FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt_s = ST_XFER;
        else         state_nxt_s = ST_IDLE;
      end
      ST_XFER: begin
        if (beat_ok_s && last_beat_s) state_nxt_s = ST_DONE;
        else                          state_nxt_s = ST_XFER;
      end
      ST_DONE: begin
        if (!biu_cyc_i) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the request latch, beat datapath and bus outputs.
  always_comb begin
    single_nxt_s = single_r;
    adr_nxt_s    = adr_r;
    beat_nxt_s   = beat_r;
    line_nxt_s   = line_r;
    dat_nxt_s    = dat_r;
    periph_nxt_s = periph_r;
    rdy_nxt_s    = rdy_r;
    addr_nxt_s   = addr_r;
    burst_nxt_s  = burst_r;
    req_nxt_s    = req_r;
    wrb_nxt_s    = wrb_r;
    wdata_nxt_s  = wdata_r;
    strobe_nxt_s = strobe_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          single_nxt_s = req_single_s;
          periph_nxt_s = req_single_s;
          adr_nxt_s    = biu_adr_i;
          beat_nxt_s   = 3'd0;
          req_nxt_s    = 1'b1;
          wrb_nxt_s    = biu_we_i;
          rdy_nxt_s    = 1'b0;
          if (req_single_s) begin
            addr_nxt_s   = biu_adr_i;
            burst_nxt_s  = BURST_NORMAL;
            strobe_nxt_s = biu_sel_i;
            wdata_nxt_s  = line_word(bus_wdata_i, biu_adr_i[4:2]);
          end else begin
            addr_nxt_s   = {biu_adr_i[31:5], 5'b00000};
            burst_nxt_s  = BURST_INCR;
            strobe_nxt_s = 4'hF;
            wdata_nxt_s  = line_word(bus_wdata_i, 3'd0);
          end
        end else begin
          req_nxt_s = 1'b0;
          rdy_nxt_s = 1'b0;
        end
      end
      ST_XFER: begin
        if (beat_ok_s) begin
          if (!wrb_r) begin
            line_nxt_s[{rd_idx_s, 5'b00000} +: 32] = RDATA;
          end else begin
            line_nxt_s = line_r;
          end
          if (!wrb_r && single_r) dat_nxt_s = RDATA;
          else                    dat_nxt_s = dat_r;
          if (last_beat_s) begin
            req_nxt_s = 1'b0;
            rdy_nxt_s = 1'b1;
          end else begin
            beat_nxt_s  = beat_inc_s;
            addr_nxt_s  = {adr_r[31:5], beat_inc_s, 2'b00};
            wdata_nxt_s = line_word(bus_wdata_i, beat_inc_s);
          end
        end else begin
          req_nxt_s = 1'b1;
        end
      end
      ST_DONE: begin
        if (!biu_cyc_i) rdy_nxt_s = 1'b0;
        else            rdy_nxt_s = 1'b1;
      end
      default: begin
        req_nxt_s = 1'b0;
        rdy_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      single_r <= 1'b0;
      adr_r    <= 32'h0000_0000;
      beat_r   <= 3'd0;
      line_r   <= '0;
      dat_r    <= 32'h0000_0000;
      periph_r <= 1'b0;
      rdy_r    <= 1'b0;
      addr_r   <= 32'h0000_0000;
      burst_r  <= BURST_NORMAL;
      req_r    <= 1'b0;
      wrb_r    <= 1'b0;
      wdata_r  <= 32'h0000_0000;
      strobe_r <= 4'h0;
    end else begin
      state_r  <= state_nxt_s;
      single_r <= single_nxt_s;
      adr_r    <= adr_nxt_s;
      beat_r   <= beat_nxt_s;
      line_r   <= line_nxt_s;
      dat_r    <= dat_nxt_s;
      periph_r <= periph_nxt_s;
      rdy_r    <= rdy_nxt_s;
      addr_r   <= addr_nxt_s;
      burst_r  <= burst_nxt_s;
      req_r    <= req_nxt_s;
      wrb_r    <= wrb_nxt_s;
      wdata_r  <= wdata_nxt_s;
      strobe_r <= strobe_nxt_s;
    end
  end

  assign bus_rdata_o       = line_r;
  assign biu_dat_o         = dat_r;
  assign bus_rdy           = rdy_r;
  assign peripheral_access = periph_r;
  assign ADDR              = addr_r;
  assign BURST             = burst_r;
  assign REQ               = req_r;
  assign WRB               = wrb_r;
  assign WDATA             = wdata_r;
  assign BSTROBE           = strobe_r;

endmodule

// File: tb/tb_dcache_bus_router.sv
// Directed bench for dcache_bus_router: single-access vector table plus
// hand-written burst, stall, freeze and reset sequences.
module tb_dcache_bus_router;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  biu_adr_i;
  logic         biu_cyc_i, biu_stb_i, biu_we_i, biu_cab_i;
  logic [3:0]   biu_sel_i;
  logic [255:0] bus_wdata_i;
  logic [255:0] bus_rdata_o;
  logic [31:0]  biu_dat_o;
  logic         bus_rdy, peripheral_access, freeze;
  logic [31:0]  ADDR, WDATA, RDATA;
  logic [1:0]   BURST;
  logic         REQ, WRB, ACK, STALL;
  logic [3:0]   BSTROBE;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_bus_router dut (
    .clk(clk), .reset(reset),
    .biu_adr_i(biu_adr_i), .biu_cyc_i(biu_cyc_i), .biu_stb_i(biu_stb_i),
    .biu_we_i(biu_we_i), .biu_cab_i(biu_cab_i), .biu_sel_i(biu_sel_i),
    .bus_wdata_i(bus_wdata_i), .bus_rdata_o(bus_rdata_o), .biu_dat_o(biu_dat_o),
    .bus_rdy(bus_rdy), .peripheral_access(peripheral_access), .freeze(freeze),
    .ADDR(ADDR), .BURST(BURST), .REQ(REQ), .WRB(WRB), .WDATA(WDATA),
    .BSTROBE(BSTROBE), .RDATA(RDATA), .ACK(ACK), .STALL(STALL)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic        cab;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fill_word(input int i);
    return bus_rdata_o[i*32 +: 32];
  endfunction

  task automatic drop_req();
    biu_cyc_i = 1'b0;
    biu_stb_i = 1'b0;
  endtask

  // Full line transfer starting from IDLE; optional stall on one beat and freeze pulse mid-burst.
  task automatic line_xfer(input logic [31:0] adr, input logic we, input int stall_beat,
                           input int stall_len, input bit freeze_mid);
    logic [31:0] base;
    int k, cyc, stalled;
    base = {adr[31:5], 5'b00000};
    k = 0; cyc = 0; stalled = 0;
    biu_adr_i = adr; biu_we_i = we; biu_cab_i = 1'b1; biu_sel_i = 4'h0;
    biu_cyc_i = 1'b1; biu_stb_i = 1'b1; ACK = 1'b0; STALL = 1'b0;
    while (k < 8 && cyc < 40) begin
      @(negedge clk); cyc++;
      chk("line_req", REQ, 1'b1);
      chk("line_rdy_low", bus_rdy, 1'b0);
      chk("line_burst", BURST, 2'b01);
      chk("line_strobe", BSTROBE, 4'hF);
      chk("line_wrb", WRB, we);
      chk("line_addr", ADDR, base + 32'(4 * k));
      if (we) chk("line_wdata", WDATA, 32'hA0 + 32'(k));
      if (freeze_mid) freeze = (cyc >= 2 && cyc <= 4);
      RDATA = we ? (32'hBAD0_0000 + 32'(k)) : (32'h100 + 32'(k));
      ACK = 1'b1;
      if (k == stall_beat && stalled < stall_len) begin
        STALL = 1'b1; stalled++;
      end else begin
        STALL = 1'b0; k++;
      end
    end
    @(negedge clk);
    ACK = 1'b0; STALL = 1'b0; freeze = 1'b0;
    chk("line_done_rdy", bus_rdy, 1'b1);
    chk("line_done_req", REQ, 1'b0);
    chk("line_periph", peripheral_access, 1'b0);
    if (!we) for (int i = 0; i < 8; i++) chk("fill_word", fill_word(i), 32'h100 + 32'(i));
    @(negedge clk);
    chk("line_rdy_hold", bus_rdy, 1'b1);
    drop_req();
    @(negedge clk);
    chk("line_rdy_release", bus_rdy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; freeze = 1'b0; biu_adr_i = 32'h0; biu_cyc_i = 1'b0; biu_stb_i = 1'b0;
    biu_we_i = 1'b0; biu_cab_i = 1'b0; biu_sel_i = 4'h0; RDATA = 32'h0; ACK = 1'b0; STALL = 1'b0;
    for (int i = 0; i < 8; i++) bus_wdata_i[i*32 +: 32] = 32'hA0 + 32'(i);

    vecs[0] = '{32'h8000_0010, 1'b0, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0,  32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_2008, 1'b1, 1'b0, 4'b1100, 32'h5555_5555, 32'hA2, 32'hDEAD_BEEF};
    vecs[2] = '{32'h0000_301C, 1'b0, 1'b0, 4'b1111, 32'h1234_5678, 32'h0,  32'h1234_5678};
    vecs[3] = '{32'h80FF_FFFC, 1'b1, 1'b1, 4'b0001, 32'h6666_6666, 32'hA7, 32'h1234_5678};

    // Reset values.
    @(negedge clk); @(negedge clk);
    chk("rst_req", REQ, 1'b0);       chk("rst_wrb", WRB, 1'b0);
    chk("rst_addr", ADDR, 32'h0);    chk("rst_burst", BURST, 2'b00);
    chk("rst_strobe", BSTROBE, 4'h0); chk("rst_wdata", WDATA, 32'h0);
    chk("rst_rdy", bus_rdy, 1'b0);   chk("rst_periph", peripheral_access, 1'b0);
    chk("rst_dat", biu_dat_o, 32'h0); chk("rst_line", bus_rdata_o, 256'h0);
    reset = 1'b1;

    // cyc without stb must not start.
    biu_cyc_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("no_stb_req", REQ, 1'b0);
    drop_req();
    @(negedge clk);

    // Line read at 0x1234, ACK every cycle.
    line_xfer(32'h0000_1234, 1'b0, -1, 0, 1'b0);
    // Line write, stall on beat 3 for 2 cycles; the fill line must survive.
    line_xfer(32'h0000_1234, 1'b1, 3, 2, 1'b0);
    for (int i = 0; i < 8; i++) chk("fill_kept", fill_word(i), 32'h100 + 32'(i));

    // Single-word vector table.
    for (int v = 0; v < 4; v++) begin
      biu_adr_i = vecs[v].adr; biu_we_i = vecs[v].we; biu_cab_i = vecs[v].cab;
      biu_sel_i = vecs[v].sel; biu_cyc_i = 1'b1; biu_stb_i = 1'b1; ACK = 1'b0;
      @(negedge clk);
      chk("single_req", REQ, 1'b1);
      chk("single_addr", ADDR, vecs[v].adr);
      chk("single_burst", BURST, 2'b00);
      chk("single_strobe", BSTROBE, vecs[v].sel);
      chk("single_wrb", WRB, vecs[v].we);
      if (vecs[v].we) chk("single_wdata", WDATA, vecs[v].exp_wdata);
      ACK = 1'b1; RDATA = vecs[v].rdata;
      @(negedge clk);
      ACK = 1'b0;
      chk("single_rdy", bus_rdy, 1'b1);
      chk("single_req_off", REQ, 1'b0);
      chk("single_periph", peripheral_access, 1'b1);
      chk("single_dat", biu_dat_o, vecs[v].exp_dat);
      if (!vecs[v].we) chk("single_fill", fill_word(int'(vecs[v].adr[4:2])), vecs[v].rdata);
      drop_req();
      @(negedge clk);
      chk("single_rdy_release", bus_rdy, 1'b0);
    end

    // Freeze held for 3 cycles blocks the start; freeze mid-burst is ignored.
    biu_adr_i = 32'h0000_7000; biu_we_i = 1'b0; biu_cab_i = 1'b1;
    biu_cyc_i = 1'b1; biu_stb_i = 1'b1; freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("freeze_req", REQ, 1'b0);
    end
    freeze = 1'b0;
    line_xfer(32'h0000_7000, 1'b0, -1, 0, 1'b1);

    // Reset during beat 4 of a line read.
    biu_adr_i = 32'h0000_5000; biu_we_i = 1'b0; biu_cab_i = 1'b1;
    biu_cyc_i = 1'b1; biu_stb_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      RDATA = 32'h300 + 32'(c - 1);
      ACK = 1'b1;
      if (c == 5) reset = 1'b0;
    end
    @(negedge clk);
    chk("mid_rst_req", REQ, 1'b0);
    chk("mid_rst_rdy", bus_rdy, 1'b0);
    chk("mid_rst_line", bus_rdata_o, 256'h0);
    reset = 1'b1; ACK = 1'b0; drop_req();
    @(negedge clk);
    line_xfer(32'h0000_6008, 1'b0, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
